// File: rtl/arb_mux.sv
// arb_mux: registered round-robin N:1 valid/ready arbitrating mux; define ARB_MUX_XFER_COUNT_EN to build the saturating xfer_count
module arb_mux #(
  parameter int WIDTH = 64,
  parameter int CHANNELS = 4,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS-1:0]                in_valid,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     in_data,
  output logic [CHANNELS-1:0]                in_ready,
  output logic                               out_valid,
  output logic [WIDTH-1:0]                   out_data,
  output logic [SELW-1:0]                    out_chan,
  input  logic                               out_ready,
  output logic [15:0]                        xfer_count
);
  logic [SELW-1:0] last_grant;
  logic [SELW-1:0] gsel;
  logic [SELW-1:0] idx;
  logic [CHANNELS-1:0] grant;
  logic found;
  logic load_en;
  logic xfer;
  assign load_en = !out_valid || out_ready;
  assign in_ready = reset ? '0 : (load_en ? grant : '0);
  assign xfer = |(in_valid & in_ready);
  always_comb begin
    grant = '0;
    gsel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = last_grant + SELW'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gsel = idx;
        grant[idx] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      last_grant <= SELW'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[gsel];
      out_chan <= gsel;
      last_grant <= gsel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef ARB_MUX_XFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) xfer_count <= '0;
    else if (xfer && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
  end
`else
  assign xfer_count = 16'h0000;
`endif
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: table-driven, scoreboard-checked bench for arb_mux with 4 channels of 64 bits
module tb_arb_mux;
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        r;
    logic [3:0]  rdy;
    logic        ov;
    logic [63:0] ld;
  } vec_t;
  typedef struct {
    logic [63:0] data;
    logic [1:0]  chan;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] in_valid;
  logic [3:0][63:0] in_data;
  logic [3:0] in_ready;
  logic out_valid;
  logic [63:0] out_data;
  logic [1:0] out_chan;
  logic out_ready;
  logic [15:0] xfer_count;
  logic [63:0] d [4];
  exp_t q[$];
  vec_t tbl [27];
  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;
  logic prev_rst;
  arb_mux #(.WIDTH(64), .CHANNELS(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_ready(out_ready),
    .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t e);
    int ch;
    exp_t x;
    ch = 0;
    for (int i = 0; i < 4; i++) if (e.rdy[i]) ch = i;
    if (e.rdy != 4'b0 && e.ld != 64'h0) d[ch] = e.ld;
    reset = e.rst;
    in_valid = e.v;
    out_ready = e.r;
    for (int i = 0; i < 4; i++) in_data[i] = d[i];
    #1;
    chk("in_ready", 64'(in_ready), 64'(e.rdy));
    chk("out_valid", 64'(out_valid), 64'(e.ov));
    if (prev_rst) begin
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_chan", 64'(out_chan), 64'h0);
    end
`ifdef ARB_MUX_XFER_COUNT_EN
    chk("xfer_count", 64'(xfer_count), 64'(n_xfer));
`else
    chk("xfer_count", 64'(xfer_count), 64'h0);
`endif
    if (e.ov) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected a pending word");
      end else begin
        chk("out_data", out_data, q[0].data);
        chk("out_chan", 64'(out_chan), 64'(q[0].chan));
        if (e.r && !e.rst) void'(q.pop_front());
      end
    end
    if (e.rst) begin
      q.delete();
      n_xfer = 0;
    end else if (e.rdy != 4'b0) begin
      x.data = d[ch];
      x.chan = 2'(ch);
      q.push_back(x);
      d[ch] = {$urandom(), $urandom()};
      n_xfer++;
    end
    prev_rst = e.rst;
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 64'hDEAD_BEEF};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 64'h0};
    tbl[2]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 64'h0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 64'h0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 64'h0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 64'h0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 64'h0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 64'h1234};
    tbl[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[10] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[11] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[12] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[13] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[14] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 64'h0};
    tbl[15] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 64'h0};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 64'h0};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0};
    tbl[18] = '{1'b0, 4'b0101, 1'b0, 4'b0001, 1'b0, 64'h0};
    tbl[19] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 1'b1, 64'h0};
    tbl[20] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 64'h0};
    tbl[21] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 64'h0};
    tbl[22] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 64'h0};
    tbl[23] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 64'h0};
    tbl[24] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 64'h0};
    tbl[25] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 64'h0};
    tbl[26] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0};
    for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
    reset = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = d[i];
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_data", out_data, 64'h0);
    chk("reset_out_chan", 64'(out_chan), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    chk("reset_xfer_count", 64'(xfer_count), 64'h0);
    prev_rst = 1'b1;
    for (int i = 0; i < 27; i++) step(tbl[i]);
`ifdef ARB_MUX_XFER_COUNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (70000) @(negedge clk);
    #1;
    chk("xfer_count_saturate", 64'(xfer_count), 64'hFFFF);
    chk("xfer_stream_valid", 64'(out_valid), 64'h1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N-way arbitrating multiplexer with valid/ready handshakes on every input and on the output. It is the sequential successor to the fixed 4:1 select mux. It merges up to 16 requesting sources, such as pipeline writeback or memory-request paths, onto one registered output channel using round-robin fairness. It sustains one transfer per cycle and holds data stable under back-pressure.

## Interface
Parameters:
- WIDTH, 64, data bits per channel; must be at least 1.
- CHANNELS, 4, number of input channels; must be a power of two, 2..16.
- SELW, $clog2(CHANNELS), channel index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  [CHANNELS-1:0]  per-channel request.
- in_data  in  [CHANNELS-1:0][WIDTH-1:0]  per-channel payload.
- in_ready  out  [CHANNELS-1:0]  per-channel accept; combinational.
- out_valid  out  1  output register holds a valid word.
- out_data  out  [WIDTH-1:0]  registered payload.
- out_chan  out  [SELW-1:0]  source channel of out_data.
- out_ready  in  1  downstream accept.
- xfer_count  out  [15:0]  accepted-input counter (see Configuration).

## Operation
- Registers:
  - output stage: out_valid, out_data, out_chan.
  - round-robin pointer last_grant [SELW-1:0].
  - xfer_count (when the feature is compiled in).
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid | out_ready.
- Grant:
  - The first channel with in_valid=1, searching last_grant+1, last_grant+2, … modulo CHANNELS.
  - At most one grant bit is set per cycle.
  - No grant when all in_valid=0.
- in_ready[i] = load_en & grant[i]. Non-granted channels see in_ready=0.
- Input transfer on channel i: in_valid[i] & in_ready[i] at a clock edge. On the edge:
  - out_data <= in_data[i]
  - out_chan <= i
  - out_valid <= 1
  - last_grant <= i
- Output transfer: out_valid & out_ready at an edge. If no input transfer occurs on the same edge, out_valid <= 0 and out_data/out_chan hold their old values.
- Simultaneous output and input transfer: the register is reloaded and out_valid stays 1, giving back-to-back throughput.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_chan are frozen and all in_ready=0.
- The grant is not locked. Arbitration is recomputed every cycle from the current in_valid.
- Source obligations:
  - Once in_valid is asserted, keep in_valid and in_data stable until the transfer.
  - Never derive in_valid from in_ready.
- Sink obligation: out_ready may depend on out_valid.
- last_grant changes only on an input transfer. Idle cycles preserve fairness.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: 1 word/cycle with out_ready held at 1.
- Reset values, forced on any edge with reset=1 regardless of activity:
  - out_valid=0, out_data=0, out_chan=0.
  - last_grant=CHANNELS-1, so channel 0 has the highest priority after reset.
  - xfer_count=0.
- During reset, in_ready is forced to 0.
- Reset mid-operation discards the held output word without any out_valid pulse. The source words pending at that time are not accepted.
- Pointer wrap: when last_grant=CHANNELS-1 the search starts at channel 0.
- Fairness: with all channels continuously valid and out_ready=1, each channel is granted exactly once per CHANNELS consecutive transfers.

## Configuration
- Macro: ARB_MUX_XFER_COUNT_EN.
- When defined:
  - xfer_count increments by 1 on every input transfer.
  - It saturates at 16'hFFFF and does not wrap.
  - It clears only on reset.
- When undefined:
  - No counter logic is built; xfer_count is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset then single request:
  - Stimulus: assert reset for 2 cycles, release, set in_valid=4'b0100 with in_data[2]=64'hDEAD_BEEF and out_ready=1.
  - Required: in_ready=4'b0100 in that cycle. Next cycle out_valid=1, out_data=64'hDEAD_BEEF, out_chan=2.
- Round-robin:
  - Stimulus: in_valid=4'b1111 held with fresh data every cycle, out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0,1 and one word per cycle.
- Back-pressure:
  - Stimulus: out_valid=1 holding 64'h1234, out_ready=0 for 5 cycles, in_valid=4'b0011.
  - Required: out_data stays 64'h1234, in_ready=0, and last_grant does not change. When out_ready returns to 1, the next grant resumes round-robin order.
- Simultaneous drain/load:
  - Stimulus: out_valid=1, out_ready=1, in_valid=4'b1000.
  - Required: out_valid stays 1, out_data is replaced by in_data[3], out_chan=3.
- Reset mid-stream:
  - Stimulus: assert reset while out_valid=1 and in_valid=4'b1111.
  - Required: on the next edge out_valid=0, out_chan=0, in_ready=0. The first grant after release is channel 0.
- Counter (ARB_MUX_XFER_COUNT_EN defined):
  - Stimulus: 70000 back-to-back transfers.
  - Required: xfer_count=16'hFFFF. With the macro undefined, xfer_count=0 throughout.
